// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the 5-stage pipeline hazard control unit.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_DWAIT  = 2'd1,
    HS_HALTED = 2'd2
  } hazard_state_t;

  typedef enum logic [1:0] {
    SC_NONE  = 2'b00,
    SC_FETCH = 2'b01,
    SC_DATA  = 2'b10,
    SC_LUSE  = 2'b11
  } stall_cause_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Load in EX whose destination is read by the instruction now in ID.
  function automatic logic load_use(input logic       ld,
                                    input logic [4:0] ld_rt,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       uses_rt);
    return ld && (ld_rt != REG_ZERO) &&
           ((ld_rt == rs) || (uses_rt && (ld_rt == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard status inputs and pipeline-register control outputs between the
// hazard unit (master) and the datapath (slave).
interface hazard_ctrl_if;
  logic       ihit;
  logic       dhit;
  logic       EX_dread;
  logic       EX_dwrite;
  logic       ID_dread;
  logic [4:0] ID_rt;
  logic [4:0] IF_rs;
  logic [4:0] IF_rt;
  logic       IF_uses_rt;
  logic       redirect;
  logic       MEM_halt;

  logic       IF_EN;
  logic       ID_EN;
  logic       EX_EN;
  logic       MEM_EN;
  logic       IF_FLUSH;
  logic       ID_FLUSH;
  logic       EX_FLUSH;
  logic       MEM_FLUSH;
  logic       pc_en;
  logic       halt;
  logic [1:0] stall_cause;

  modport master (
    input  ihit, dhit, EX_dread, EX_dwrite, ID_dread, ID_rt, IF_rs, IF_rt,
           IF_uses_rt, redirect, MEM_halt,
    output IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH,
           MEM_FLUSH, pc_en, halt, stall_cause
  );

  modport slave (
    output ihit, dhit, EX_dread, EX_dwrite, ID_dread, ID_rt, IF_rs, IF_rt,
           IF_uses_rt, redirect, MEM_halt,
    input  IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH,
           MEM_FLUSH, pc_en, halt, stall_cause
  );
endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// Saturating event counter for hazard statistics; present only when
// HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (clr)      cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline enable/flush/PC-advance arbitration for the 5-stage MIPS datapath.
// Optional HAZARD_PERF_EN adds saturating stall and redirect-flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  hazard_ctrl_if.master    hif
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN    = HS_RUN;
  localparam logic [1:0] ST_DWAIT  = HS_DWAIT;
  localparam logic [1:0] ST_HALTED = HS_HALTED;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [3:0]   en_c;       // {IF, ID, EX, MEM}
  logic [3:0]   flush_c;    // {IF, ID, EX, MEM}
  logic         pc_en_c;
  logic         redirect_fl;
  stall_cause_t cause_c;

  logic mem_op;
  logic luse;
  logic data_wait;
  logic data_done;

  assign mem_op    = hif.EX_dread | hif.EX_dwrite;
  assign luse      = load_use(hif.ID_dread, hif.ID_rt, hif.IF_rs, hif.IF_rt,
                              hif.IF_uses_rt);
  assign data_wait = !hif.dhit && ((state == ST_RUN && mem_op) ||
                                   (state == ST_DWAIT));
  assign data_done = mem_op && hif.dhit;

  always_comb begin
    en_c        = 4'b0000;
    flush_c     = 4'b0000;
    pc_en_c     = 1'b0;
    redirect_fl = 1'b0;
    cause_c     = SC_NONE;
    if (!nRST) begin
      flush_c = 4'b1111;
    end else if (state == ST_HALTED) begin
      en_c = 4'b0000;
    end else if (data_wait) begin
      cause_c = SC_DATA;
    end else if (!hif.ihit) begin
      cause_c = SC_FETCH;
      // Retire the finished access and bubble EX/MEM so it is not replayed.
      if (data_done) begin
        en_c    = 4'b0011;
        flush_c = 4'b0010;
      end
    end else if (hif.redirect) begin
      en_c        = 4'b1111;
      flush_c     = 4'b1110;
      pc_en_c     = 1'b1;
      redirect_fl = 1'b1;
    end else if (luse) begin
      en_c    = 4'b0111;
      flush_c = 4'b0100;
      cause_c = SC_LUSE;
    end else begin
      en_c    = 4'b1111;
      pc_en_c = 1'b1;
    end
  end

  always_comb begin
    state_nxt = ST_RUN;
    if (hif.MEM_halt || state == ST_HALTED) state_nxt = ST_HALTED;
    else if (data_wait)                     state_nxt = ST_DWAIT;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state <= ST_RUN;
    else       state <= state_nxt;
  end

  assign hif.IF_EN       = en_c[3];
  assign hif.ID_EN       = en_c[2];
  assign hif.EX_EN       = en_c[1];
  assign hif.MEM_EN      = en_c[0];
  assign hif.IF_FLUSH    = flush_c[3];
  assign hif.ID_FLUSH    = flush_c[2];
  assign hif.EX_FLUSH    = flush_c[1];
  assign hif.MEM_FLUSH   = flush_c[0];
  assign hif.pc_en       = pc_en_c;
  assign hif.stall_cause = cause_c;
  // halt comes straight from the state register, held low while in reset.
  assign hif.halt        = (state == ST_HALTED) && nRST;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .clr (!nRST),
    .inc (cause_c != SC_NONE),
    .cnt (perf_stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK (CLK),
    .clr (!nRST),
    .inc (redirect_fl),
    .cnt (perf_flush_cnt)
  );
`else
  // Counter width has no consumer in this build.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
